// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package loader_pkg;

    typedef enum logic [2:0] {
        ST_HDR,
        ST_DATA,
        ST_WRITE,
        ST_CKSUM,
        ST_DONE,
        ST_ERR
    } state_e;

    localparam int HDR_BYTES  = 4;
    localparam int WORD_BYTES = 4;

    // States in which the loader is willing to take a stream byte.
    function automatic logic is_rx_state(input state_e s);
        return (s == ST_HDR) || (s == ST_DATA) || (s == ST_CKSUM);
    endfunction

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Packs four consecutive bytes, MSB first, into one 32-bit word.
module byte_packer
    import loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    logic [1:0]  cnt_q;
    logic [23:0] sh_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            sh_q  <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
            sh_q  <= '0;
        end else if (byte_valid_i) begin
            cnt_q <= cnt_q + 2'd1;
            sh_q  <= {sh_q[15:0], byte_i};
        end
    end

    // The completing byte goes straight into the low lane so the word is usable the same cycle.
    assign word_o       = {sh_q, byte_i};
    assign word_valid_o = byte_valid_i && (cnt_q == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/prog_loader.sv
// Loads a length-prefixed byte stream into instruction memory and holds the CPU in reset until done.
// Optional trailing XOR checksum byte is enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader
    import loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 1024,
    parameter int          ADDR_W    = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_data_i,
    output logic              byte_ready_o,
    input  logic              load_start_i,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_wdata_o,
    output logic              cpu_rst_n_o,
    output logic              done_o,
    output logic              err_o
);

    state_e            state_q, state_d;
    logic [31:0]       n_q;
    logic [31:0]       k_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;

    logic        xfer;
    logic        pk_valid;
    logic        restart;
    logic        last_word;
    logic [31:0] word;
    logic        word_valid;

    // Ready is forced low while reset is asserted so nothing is handshaken during reset.
    assign byte_ready_o = rst_i && is_rx_state(state_q);
    assign xfer         = byte_valid_i && byte_ready_o;
    assign pk_valid     = xfer && ((state_q == ST_HDR) || (state_q == ST_DATA));
    assign restart      = ((state_q == ST_DONE) || (state_q == ST_ERR)) && load_start_i;
    assign last_word    = (k_q >= (n_q - 32'd1));

    byte_packer u_packer (
        .clk_i        (clk_i),
        .rst_ni       (rst_i),
        .clear_i      (restart),
        .byte_valid_i (pk_valid),
        .byte_i       (byte_data_i),
        .word_o       (word),
        .word_valid_o (word_valid)
    );

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] csum_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            csum_q <= '0;
        end else if (restart) begin
            csum_q <= '0;
        end else if (pk_valid) begin
            csum_q <= csum_q ^ byte_data_i;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HDR: begin
                if (word_valid) begin
                    if (word == 32'd0)                    state_d = ST_DONE;
                    else if (word > 32'(MAX_WORDS))       state_d = ST_ERR;
                    else                                  state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (word_valid) state_d = ST_WRITE;
            end
            ST_WRITE: begin
`ifdef PROG_LOADER_CHECKSUM_EN
                state_d = last_word ? ST_CKSUM : ST_DATA;
`else
                state_d = last_word ? ST_DONE : ST_DATA;
`endif
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            ST_CKSUM: begin
                if (xfer) state_d = (byte_data_i == csum_q) ? ST_DONE : ST_ERR;
            end
`endif
            ST_DONE, ST_ERR: begin
                if (load_start_i) state_d = ST_HDR;
            end
            default: state_d = ST_HDR;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_HDR;
            n_q     <= '0;
            k_q     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (restart) begin
                n_q <= '0;
                k_q <= '0;
            end else if ((state_q == ST_HDR) && word_valid) begin
                n_q <= word;
                k_q <= '0;
            end else if ((state_q == ST_WRITE) && !last_word) begin
                k_q <= k_q + 32'd1;
            end
            // Address and data are captured on entry to WRITE and then held.
            if ((state_q == ST_DATA) && word_valid) begin
                wdata_q <= word;
                addr_q  <= ADDR_W'(BASE_ADDR + (k_q << 2));
            end
        end
    end

    assign imem_we_o    = (state_q == ST_WRITE);
    assign imem_addr_o  = addr_q;
    assign imem_wdata_o = wdata_q;
    assign cpu_rst_n_o  = (state_q == ST_DONE);
    assign done_o       = (state_q == ST_DONE);
    assign err_o        = (state_q == ST_ERR);

endmodule
